// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with one shared up/down counter.
// Duty, period and mode are double-buffered and swap in at period start.
module pwm_bank #(
  parameter int NCH            = 8,
  parameter int CW             = 7,
  parameter int DEFAULT_PERIOD = 99,
  parameter int SW             = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_wr,
  input  logic [SW-1:0]  cfg_sel,
  input  logic [CW-1:0]  cfg_duty,
  input  logic           per_wr,
  input  logic [CW-1:0]  per_in,
  input  logic           mode_in,
  input  logic [NCH-1:0] enable,
  input  logic [NCH-1:0] invert,
  output logic [NCH-1:0] pwm_out,
  output logic           period_start
);

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] DEF_P = CW'(DEFAULT_PERIOD);
  localparam logic [SW:0]   NCH_W = (SW+1)'(NCH);

  logic [CW-1:0]  count;
  logic [CW-1:0]  cnt_nxt;
  logic           dir;
  logic           dir_nxt;
  logic           boundary;
  logic           p_zero;
  logic           sel_ok;

  logic [CW-1:0]  duty_sh  [NCH];
  logic [CW-1:0]  duty_act [NCH];
  logic [CW-1:0]  duty_nxt [NCH];
  logic [CW-1:0]  per_sh;
  logic [CW-1:0]  per_act;
  logic           mode_sh;
  logic           mode_act;
  logic [NCH-1:0] pwm_nxt;

  assign p_zero = (per_act == '0);
  assign sel_ok = ({1'b0, cfg_sel} < NCH_W);

  // Next counter state and boundary detection for the active mode.
  always_comb begin
    boundary = 1'b0;
    cnt_nxt  = count;
    dir_nxt  = dir;
    unique case (1'b1)
      p_zero: begin
        boundary = 1'b1;
        cnt_nxt  = '0;
        dir_nxt  = 1'b0;
      end
      (!p_zero && !mode_act): begin
        dir_nxt = 1'b0;
        if (count >= per_act) begin
          boundary = 1'b1;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = count + ONE;
        end
      end
      (!p_zero && mode_act && !dir): begin
        if (count >= per_act - ONE) begin
          dir_nxt = 1'b1;
        end else begin
          cnt_nxt = count + ONE;
        end
      end
      (!p_zero && mode_act && dir): begin
        if (count == '0) begin
          boundary = 1'b1;
          cnt_nxt  = '0;
          dir_nxt  = 1'b0;
        end else begin
          cnt_nxt = count - ONE;
        end
      end
      default: begin
        cnt_nxt = count;
      end
    endcase
  end

  // Compare next count against next actives so outputs align with count.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      duty_nxt[i] = boundary ? duty_sh[i] : duty_act[i];
      pwm_nxt[i]  = enable[i]
                  ? ((cnt_nxt < duty_nxt[i]) ^ invert[i])
                  : invert[i];
    end
  end

  // Shadow registers, written any time by the config strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_sh  <= DEF_P;
      mode_sh <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        duty_sh[i] <= '0;
      end
    end else begin
      if (per_wr) begin
        per_sh  <= per_in;
        mode_sh <= mode_in;
      end
      for (int i = 0; i < NCH; i++) begin
        if (cfg_wr && sel_ok && (cfg_sel == SW'(i))) begin
          duty_sh[i] <= cfg_duty;
        end
      end
    end
  end

  // Counter, actives (loaded at boundary) and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      dir          <= 1'b0;
      per_act      <= DEF_P;
      mode_act     <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        duty_act[i] <= '0;
      end
    end else begin
      count        <= cnt_nxt;
      dir          <= dir_nxt;
      pwm_out      <= pwm_nxt;
      period_start <= boundary;
      if (boundary) begin
        per_act  <= per_sh;
        mode_act <= mode_sh;
      end
      for (int i = 0; i < NCH; i++) begin
        duty_act[i] <= duty_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed scenario bench for pwm_bank.
// Inputs driven and outputs sampled on the falling edge.
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [6:0] cfg_duty = '0;
  logic       per_wr = 1'b0;
  logic [6:0] per_in = '0;
  logic       mode_in = 1'b0;
  logic [7:0] enable = '0;
  logic [7:0] invert = '0;
  logic [7:0] pwm_out;
  logic       period_start;

  int checks = 0;
  int errors = 0;
  int hi [8];
  int ps_cnt;
  int wait_n;

  pwm_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_sel      (cfg_sel),
    .cfg_duty     (cfg_duty),
    .per_wr       (per_wr),
    .per_in       (per_in),
    .mode_in      (mode_in),
    .enable       (enable),
    .invert       (invert),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic wr_duty(input int ch, input int d);
    cfg_wr   = 1'b1;
    cfg_sel  = 3'(ch);
    cfg_duty = 7'(d);
    @(negedge clk);
    cfg_wr   = 1'b0;
  endtask

  task automatic wr_both(input int ch, input int d,
                         input int p, input int m);
    cfg_wr   = 1'b1;
    cfg_sel  = 3'(ch);
    cfg_duty = 7'(d);
    per_wr   = 1'b1;
    per_in   = 7'(p);
    mode_in  = (m != 0);
    @(negedge clk);
    cfg_wr   = 1'b0;
    per_wr   = 1'b0;
  endtask

  task automatic measure(input int n);
    for (int i = 0; i < 8; i++) hi[i] = 0;
    ps_cnt = 0;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) if (pwm_out[i]) hi[i]++;
      if (period_start) ps_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ps(input string tag);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (period_start !== 1'b1 && wait_n < 300);
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout got=%b want=1", tag, period_start);
    end
  endtask

  function automatic int others(input int a, input int b, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++)
      if (i != a && i != b && i != c) s += hi[i];
    return s;
  endfunction

  task automatic test_reset;
    enable = 8'hFF;
    invert = 8'hFF;
    @(negedge clk);
    checks++;
    if (pwm_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_pwm got=%h want=00", pwm_out);
    end
    checks++;
    if (period_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_ps got=%b want=0", period_start);
    end
    checks++;
    if (dut.count !== 7'd0) begin
      errors++;
      $display("FAIL rst_count got=%0d want=0", dut.count);
    end
    enable = 8'h00;
    invert = 8'h00;
    rst_n  = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.count !== 7'd1) begin
      errors++;
      $display("FAIL first_count got=%0d want=1", dut.count);
    end
    checks++;
    if (period_start !== 1'b0) begin
      errors++;
      $display("FAIL first_ps got=%b want=0", period_start);
    end
  endtask

  task automatic test_edge;
    enable = 8'b0010_0101;
    wr_duty(0, 20);
    wr_duty(2, 40);
    wr_duty(5, 60);
    wait_ps("edge_sync");
    measure(100);
    checks++;
    if (hi[0] != 20) begin
      errors++;
      $display("FAIL edge_ch0 got=%0d want=20", hi[0]);
    end
    checks++;
    if (hi[2] != 40) begin
      errors++;
      $display("FAIL edge_ch2 got=%0d want=40", hi[2]);
    end
    checks++;
    if (hi[5] != 60) begin
      errors++;
      $display("FAIL edge_ch5 got=%0d want=60", hi[5]);
    end
    checks++;
    if (others(0, 2, 5) != 0) begin
      errors++;
      $display("FAIL edge_others got=%0d want=0", others(0, 2, 5));
    end
    checks++;
    if (ps_cnt != 1) begin
      errors++;
      $display("FAIL edge_ps_cnt got=%0d want=1", ps_cnt);
    end
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL edge_period got=%b want=1", period_start);
    end
  endtask

  task automatic test_boundary;
    wr_both(0, 0, 9, 0);
    wait_ps("bnd_sync0");
    measure(20);
    checks++;
    if (hi[0] != 0 || ps_cnt != 2) begin
      errors++;
      $display("FAIL bnd_d0 got=%0d/%0d want=0/2", hi[0], ps_cnt);
    end
    wr_duty(0, 10);
    wait_ps("bnd_sync10");
    measure(20);
    checks++;
    if (hi[0] != 20) begin
      errors++;
      $display("FAIL bnd_d10 got=%0d want=20", hi[0]);
    end
    wr_duty(0, 15);
    wait_ps("bnd_sync15");
    measure(20);
    checks++;
    if (hi[0] != 20) begin
      errors++;
      $display("FAIL bnd_d15 got=%0d want=20", hi[0]);
    end
  endtask

  task automatic test_shadow;
    enable = 8'b0000_0010;
    wr_duty(1, 3);
    wait_ps("sh_sync");
    measure(4);
    checks++;
    if (hi[1] != 3) begin
      errors++;
      $display("FAIL sh_head got=%0d want=3", hi[1]);
    end
    wr_duty(1, 7);
    measure(5);
    checks++;
    if (hi[1] != 0 || ps_cnt != 0) begin
      errors++;
      $display("FAIL sh_tail got=%0d/%0d want=0/0", hi[1], ps_cnt);
    end
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL sh_ps got=%b want=1", period_start);
    end
    measure(9);
    checks++;
    if (hi[1] != 7) begin
      errors++;
      $display("FAIL sh_new got=%0d want=7", hi[1]);
    end
    wr_duty(1, 2);
    measure(10);
    checks++;
    if (hi[1] != 7) begin
      errors++;
      $display("FAIL sh_bnd_hold got=%0d want=7", hi[1]);
    end
    measure(10);
    checks++;
    if (hi[1] != 2) begin
      errors++;
      $display("FAIL sh_bnd_apply got=%0d want=2", hi[1]);
    end
  endtask

  task automatic test_center;
    int bad;
    logic [15:0] pat;
    enable = 8'h01;
    wr_both(0, 3, 8, 1);
    wait_ps("ctr_sync");
    bad = 0;
    pat = '0;
    ps_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (dut.count !== 7'((k < 8) ? k : 15 - k)) bad++;
      pat[k] = pwm_out[0];
      if (period_start) ps_cnt++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ctr_seq got=%0d bad want=0", bad);
    end
    checks++;
    if (pat !== 16'hE007) begin
      errors++;
      $display("FAIL ctr_pat got=%h want=e007", pat);
    end
    checks++;
    if (ps_cnt != 1 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL ctr_period got=%0d/%b want=1/1", ps_cnt, period_start);
    end
    wr_duty(0, 8);
    wait_ps("ctr_sync8");
    measure(32);
    checks++;
    if (hi[0] != 32) begin
      errors++;
      $display("FAIL ctr_full got=%0d want=32", hi[0]);
    end
  endtask

  task automatic test_polarity;
    enable = 8'h00;
    invert = 8'h08;
    wr_both(3, 2, 4, 0);
    wait_ps("pol_sync");
    measure(10);
    checks++;
    if (hi[3] != 10) begin
      errors++;
      $display("FAIL pol_dis got=%0d want=10", hi[3]);
    end
    enable = 8'h08;
    wait_ps("pol_sync2");
    checks++;
    if (pwm_out[3] !== 1'b0) begin
      errors++;
      $display("FAIL pol_c0 got=%b want=0", pwm_out[3]);
    end
    measure(10);
    checks++;
    if (hi[3] != 6) begin
      errors++;
      $display("FAIL pol_en got=%0d want=6", hi[3]);
    end
  endtask

  task automatic test_reset_p0;
    invert = 8'h00;
    enable = 8'hFF;
    wr_both(0, 50, 20, 0);
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got=%b want=1", pwm_out[0]);
    end
    invert = 8'hF0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 8'h00 || dut.count !== 7'd0) begin
      errors++;
      $display("FAIL async_rst got=%h/%0d want=00/0", pwm_out, dut.count);
    end
    @(negedge clk);
    invert = 8'h00;
    rst_n  = 1'b1;
    measure(100);
    checks++;
    if (others(8, 8, 8) != 0 || ps_cnt != 0) begin
      errors++;
      $display("FAIL post_rst got=%0d/%0d want=0/0",
               others(8, 8, 8), ps_cnt);
    end
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_p99 got=%b want=1", period_start);
    end
    wr_both(0, 1, 0, 0);
    wait_ps("p0_sync");
    measure(10);
    checks++;
    if (ps_cnt != 10) begin
      errors++;
      $display("FAIL p0_ps got=%0d want=10", ps_cnt);
    end
    checks++;
    if (hi[0] != 10 || others(0, 0, 0) != 0) begin
      errors++;
      $display("FAIL p0_out got=%0d/%0d want=10/0",
               hi[0], others(0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_boundary();
    test_shadow();
    test_center();
    test_polarity();
    test_reset_p0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
